// File: rtl/dmem_bridge_pkg.sv
// Shared types and constants for the data-side memory bridge.
package dmem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    localparam logic [1:0] OFS_OUT    = 2'd0;
    localparam logic [1:0] OFS_IN     = 2'd1;
    localparam logic [1:0] OFS_CYC    = 2'd2;
    localparam logic [1:0] OFS_STATUS = 2'd3;

    localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

endpackage

// File: rtl/dmem_bridge_sync2.sv
// Two-flop synchronizer for asynchronous inputs, async active-high reset.
module sync2 #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dmem_bridge.sv
// Data-side bridge: decodes RAM / IO / unmapped regions, runs the RAM
// valid/ack handshake with a timeout and stalls the core until it completes.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int unsigned RAM_WORDS = 1024,
    parameter logic [31:0] IO_BASE   = 32'h0000_4000,
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned IO_OUT_W  = 8,
    parameter int unsigned IO_IN_W   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         MemWrite,
    input  logic                         MemRead,
    input  logic [31:0]                  Addr,
    input  logic [31:0]                  WriteData,
    output logic [31:0]                  ReadData,
    output logic                         Stall,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [$clog2(RAM_WORDS)-1:0] mem_addr,
    output logic [31:0]                  mem_wdata,
    input  logic                         mem_ack,
    input  logic [31:0]                  mem_rdata,
    input  logic [IO_IN_W-1:0]           io_in,
    output logic [IO_OUT_W-1:0]          io_out,
    output logic                         bus_err
);

    localparam int unsigned AW = $clog2(RAM_WORDS);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    state_t             state, state_n;
    logic [TW-1:0]      tcnt;
    logic [31:0]        rdata_q;
    logic [31:0]        cyc;
    logic [IO_IN_W-1:0] io_in_s;

    logic       access, is_ram, is_io, is_unm, timeout, io_wr, unm_hit;
    logic [1:0] ofs;

    assign access  = MemRead | MemWrite;
    assign is_ram  = Addr < RAM_WORDS;
    assign is_io   = (Addr >= IO_BASE) && (Addr <= IO_BASE + 32'd3);
    assign is_unm  = !is_ram && !is_io;
    assign ofs     = 2'(Addr - IO_BASE);
    assign timeout = (state == REQ) && !mem_ack && (tcnt == TW'(TIMEOUT - 1));
    assign io_wr   = MemWrite && is_io && !Stall;
    assign unm_hit = access && is_unm && !Stall;

    sync2 #(.W(IO_IN_W)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (io_in),
        .q     (io_in_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        Stall   = 1'b0;
        mem_req = 1'b0;
        case (state)
            IDLE: begin
                if (access && is_ram) begin
                    Stall   = 1'b1;
                    state_n = REQ;
                end
            end
            REQ: begin
                Stall   = 1'b1;
                mem_req = 1'b1;
                if (mem_ack || timeout) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Request fields are captured once in IDLE and held for the whole REQ phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            tcnt      <= '0;
            rdata_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access && is_ram) begin
                        mem_addr  <= Addr[AW-1:0];
                        mem_wdata <= WriteData;
                        mem_we    <= MemWrite;
                        tcnt      <= '0;
                    end
                end
                REQ: begin
                    tcnt <= tcnt + 1'b1;
                    if (mem_ack) begin
                        if (!mem_we) rdata_q <= mem_rdata;
                    end else if (timeout) begin
                        rdata_q <= ERR_WORD;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            io_out  <= '0;
            cyc     <= '0;
            bus_err <= 1'b0;
        end else begin
            if (io_wr && ofs == OFS_OUT) io_out <= WriteData[IO_OUT_W-1:0];
            if (io_wr && ofs == OFS_CYC) cyc <= '0;
            else                         cyc <= cyc + 32'd1;
            // A new error in the same cycle beats a software clear.
            if (timeout || unm_hit)                             bus_err <= 1'b1;
            else if (io_wr && ofs == OFS_STATUS && WriteData[0]) bus_err <= 1'b0;
        end
    end

    always_comb begin
        ReadData = '0;
        if (state == DONE) begin
            ReadData = MemWrite ? '0 : rdata_q;
        end else if (state == IDLE && MemRead && !MemWrite && is_io) begin
            case (ofs)
                OFS_OUT:    ReadData = 32'(io_out);
                OFS_IN:     ReadData = 32'(io_in_s);
                OFS_CYC:    ReadData = cyc;
                OFS_STATUS: ReadData = {31'd0, bus_err};
                default:    ReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: directed scenarios plus a randomized
// mix of RAM / IO / unmapped accesses checked against a behavioural model.
module tb_dmem_bridge;

    localparam int unsigned RAM_WORDS = 1024;
    localparam logic [31:0] IO_BASE   = 32'h0000_4000;
    localparam int unsigned TIMEOUT   = 16;

    logic        clk = 1'b0, reset = 1'b1;
    logic        MemWrite = 1'b0, MemRead = 1'b0;
    logic [31:0] Addr = '0, WriteData = '0, ReadData;
    logic        Stall, mem_req, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [7:0]  io_in = '0, io_out;
    logic        bus_err;

    int checks = 0;
    int fails  = 0;

    logic [31:0] ram_m [RAM_WORDS];
    logic [7:0]  out_m = '0;
    logic        err_m = 1'b0;

    always #5 clk = ~clk;

    dmem_bridge #(
        .RAM_WORDS (RAM_WORDS),
        .IO_BASE   (IO_BASE),
        .TIMEOUT   (TIMEOUT),
        .IO_OUT_W  (8),
        .IO_IN_W   (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .io_in     (io_in),
        .io_out    (io_out),
        .bus_err   (bus_err)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Addr      = '0;
        WriteData = '0;
    endtask

    // ack_at: REQ cycle (1-based) in which the RAM acks; 0 means never.
    task automatic ram_access(input logic wr, input logic [31:0] addr,
                              input logic [31:0] wd, input int ack_at);
        int          req_n = 0;
        int          stalls = 0;
        int          exp_stalls;
        logic        done = 1'b0;
        logic        acked;
        logic [31:0] rd, exp_rd;
        acked = (ack_at >= 1) && (ack_at <= int'(TIMEOUT));
        rd = ram_m[addr[9:0]];
        MemWrite = wr; MemRead = ~wr; Addr = addr; WriteData = wd;
        for (int c = 0; c < 40 && !done; c++) begin
            if (mem_req) begin
                req_n++;
                checks++;
                if (mem_addr !== addr[9:0] || mem_we !== wr || mem_wdata !== wd) begin
                    fails++;
                    $display("FAIL ram_hold: addr=%h we=%b wdata=%h required addr=%h we=%b wdata=%h",
                             mem_addr, mem_we, mem_wdata, addr[9:0], wr, wd);
                end
                if (req_n == ack_at) begin
                    mem_ack = 1'b1;
                    mem_rdata = wr ? $urandom : rd;
                end
            end
            @(negedge clk);
            if (Stall) stalls++;
            else       done = 1'b1;
            if (!done) begin
                step();
                mem_ack = 1'b0;
            end
        end
        exp_stalls = acked ? 1 + ack_at : 1 + int'(TIMEOUT);
        exp_rd = wr ? 32'd0 : (acked ? rd : 32'hDEAD_BEEF);
        checks++;
        if (!done || stalls != exp_stalls) begin
            fails++;
            $display("FAIL ram_stalls: got %0d (done=%b) required %0d", stalls, done, exp_stalls);
        end
        checks++;
        if (ReadData !== exp_rd) begin
            fails++;
            $display("FAIL ram_rdata: got %h required %h", ReadData, exp_rd);
        end
        if (wr && acked) ram_m[addr[9:0]] = wd;
        if (!acked) err_m = 1'b1;
        step();
        idle();
        checks++;
        if (bus_err !== err_m) begin
            fails++;
            $display("FAIL ram_bus_err: got %b required %b", bus_err, err_m);
        end
    endtask

    // Single-cycle IO or unmapped access; CYC reads are returned, not checked.
    task automatic io_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wd, output logic [31:0] got);
        logic        io;
        logic [1:0]  ofs;
        logic [31:0] exp;
        logic        chk;
        io  = (addr >= IO_BASE) && (addr <= IO_BASE + 32'd3);
        ofs = 2'(addr - IO_BASE);
        exp = '0;
        chk = 1'b1;
        if (io && rd && !wr) begin
            case (ofs)
                2'd0: exp = {24'd0, out_m};
                2'd1: exp = {24'd0, io_in};
                2'd2: chk = 1'b0;
                default: exp = {31'd0, err_m};
            endcase
        end
        MemRead = rd; MemWrite = wr; Addr = addr; WriteData = wd;
        @(negedge clk);
        got = ReadData;
        checks++;
        if (Stall !== 1'b0) begin
            fails++;
            $display("FAIL io_stall: got %b required 0 (addr %h)", Stall, addr);
        end
        if (chk) begin
            checks++;
            if (ReadData !== exp) begin
                fails++;
                $display("FAIL io_rdata: addr %h got %h required %h", addr, ReadData, exp);
            end
        end
        if (io && wr && ofs == 2'd0) out_m = wd[7:0];
        if (io && wr && ofs == 2'd3 && wd[0]) err_m = 1'b0;
        if (!io && (rd || wr)) err_m = 1'b1;
        step();
        idle();
        checks++;
        if (io_out !== out_m || bus_err !== err_m) begin
            fails++;
            $display("FAIL io_effect: io_out=%h bus_err=%b required %h %b", io_out, bus_err, out_m, err_m);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        checks++;
        if (ReadData !== '0 || Stall !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0 ||
            mem_addr !== '0 || mem_wdata !== '0 || io_out !== '0 || bus_err !== 1'b0) begin
            fails++;
            $display("FAIL reset: rd=%h st=%b req=%b we=%b ad=%h wd=%h out=%h err=%b required all 0",
                     ReadData, Stall, mem_req, mem_we, mem_addr, mem_wdata, io_out, bus_err);
        end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_ram_read;
        ram_m[5] = 32'h1234_5678;
        ram_access(1'b0, 32'd5, 32'h0, 3);
    endtask

    task automatic test_ram_write_min;
        ram_access(1'b1, RAM_WORDS - 1, 32'hCAFE_F00D, 1);
    endtask

    task automatic test_timeout;
        logic [31:0] g;
        ram_access(1'b0, 32'd7, 32'h0, 0);
        io_access(1'b1, 1'b0, IO_BASE + 32'd3, 32'h0, g);
        io_access(1'b0, 1'b1, IO_BASE + 32'd3, 32'h1, g);
        io_access(1'b1, 1'b0, IO_BASE + 32'd3, 32'h0, g);
    endtask

    task automatic test_io;
        logic [31:0] g, c0, c1;
        io_access(1'b0, 1'b1, IO_BASE, 32'h0000_00A5, g);
        io_in = 8'h3C;
        step(); step();
        io_access(1'b1, 1'b0, IO_BASE + 32'd1, 32'h0, g);
        io_access(1'b0, 1'b1, IO_BASE + 32'd1, 32'hFFFF_FFFF, g);
        io_access(1'b0, 1'b1, IO_BASE + 32'd2, 32'h1234, g);
        step();
        io_access(1'b1, 1'b0, IO_BASE + 32'd2, 32'h0, c0);
        checks++;
        if (c0 !== 32'd1) begin
            fails++;
            $display("FAIL cyc_clear: got %h required 1", c0);
        end
        repeat (3) step();
        io_access(1'b1, 1'b0, IO_BASE + 32'd2, 32'h0, c1);
        checks++;
        if (c1 - c0 !== 32'd4) begin
            fails++;
            $display("FAIL cyc_count: delta %0d required 4", c1 - c0);
        end
        io_access(1'b1, 1'b1, IO_BASE, 32'h0000_0077, g);
    endtask

    task automatic test_unmapped;
        logic [31:0] g;
        io_access(1'b1, 1'b0, 32'h0000_8000, 32'h0, g);
        io_access(1'b0, 1'b1, 32'h0000_0400, 32'h55, g);
        io_access(1'b0, 1'b1, IO_BASE + 32'd3, 32'h1, g);
    endtask

    task automatic test_reset_mid;
        logic [31:0] g;
        io_access(1'b1, 1'b0, IO_BASE + 32'd4, 32'h0, g);
        io_access(1'b0, 1'b1, IO_BASE, 32'h5A, g);
        MemRead = 1'b1; Addr = 32'd9;
        step(); step();
        #2 reset = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || io_out !== '0 || bus_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: req=%b out=%h err=%b required 0 0 0", mem_req, io_out, bus_err);
        end
        idle();
        out_m = '0; err_m = 1'b0;
        step();
        reset = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        checks++;
        if (ReadData !== '0 || Stall !== 1'b0 || mem_req !== 1'b0) begin
            fails++;
            $display("FAIL late_ack: rd=%h st=%b req=%b required 0 0 0", ReadData, Stall, mem_req);
        end
        step();
        mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (ReadData !== '0 || mem_req !== 1'b0 || bus_err !== 1'b0) begin
            fails++;
            $display("FAIL late_ack_after: rd=%h req=%b err=%b required 0 0 0", ReadData, mem_req, bus_err);
        end
        step(); step();
    endtask

    task automatic test_random;
        logic [31:0] g, a;
        int          k;
        io_in = 8'($urandom);
        repeat (3) step();
        for (int n = 0; n < 60; n++) begin
            k = int'($urandom_range(0, 5));
            case (k)
                0, 1: ram_access(k == 1, $urandom_range(0, RAM_WORDS - 1), $urandom,
                                 int'($urandom_range(0, 5)));
                2: begin
                    a = IO_BASE + 32'($urandom_range(0, 2));
                    if (a == IO_BASE + 32'd2) a = IO_BASE + 32'd3;
                    io_access(1'b1, 1'b0, a, 32'h0, g);
                end
                3: io_access(1'b0, 1'b1, IO_BASE + 32'($urandom_range(0, 3)), $urandom, g);
                4: begin
                    a = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(RAM_WORDS, IO_BASE - 1))
                                                    : IO_BASE + 32'd4 + 32'($urandom_range(0, 5000));
                    io_access($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, a, $urandom, g);
                end
                default: io_access(1'b1, 1'b1, IO_BASE + 32'($urandom_range(0, 3)), $urandom, g);
            endcase
        end
    endtask

    initial begin
        for (int i = 0; i < int'(RAM_WORDS); i++) ram_m[i] = $urandom;
        test_reset();
        test_ram_read();
        test_ram_write_min();
        test_timeout();
        test_io();
        test_unmapped();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
